// File: rtl/bus_transfer_arbiter.sv
// -----------------------------------------------------------------------------
// bus_transfer_arbiter
//
// Round-robin arbiter and sequencer for the shared 16-bit register bus.
// Each requester asks for one register-to-register move (source, destination).
// One requester at a time is granted the bus. For that requester the block
// drives the one-hot register strobes in the order bus-drive, write, complete.
// No other agent drives LDBUS or WR on this bus, so two sources never drive
// the tri-state bus at the same time.
//
// Ports
//   clk    : clock, rising edge
//   RST    : asynchronous active-high reset
//   REQ    : per-requester request level (N_REQ)
//   SRC    : packed source indices, requester i at [i*SEL_W +: SEL_W]
//   DST    : packed destination indices, same packing as SRC
//   GNT    : one-hot grant, held DRIVE..COMPLETE
//   DONE   : one-cycle completion pulse to the granted requester
//   ERR    : pulses with DONE when the latched src or dst is >= N_REG
//   LDBUS  : one-hot bus-drive strobes (DRIVE and WRITE)
//   WR     : one-hot write strobes (WRITE)
//   BUSY   : high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module bus_transfer_arbiter #(
   parameter int N_REQ = 4,
   parameter int N_REG = 8,
   parameter int SEL_W = 3
) (
   input  logic                   clk,
   input  logic                   RST,
   input  logic [N_REQ-1:0]       REQ,
   input  logic [N_REQ*SEL_W-1:0] SRC,
   input  logic [N_REQ*SEL_W-1:0] DST,
   output logic [N_REQ-1:0]       GNT,
   output logic [N_REQ-1:0]       DONE,
   output logic                   ERR,
   output logic [N_REG-1:0]       LDBUS,
   output logic [N_REG-1:0]       WR,
   output logic                   BUSY
);

   localparam int PTR_W = $clog2(N_REQ);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DRIVE    = 2'd1,
      WRITE    = 2'd2,
      COMPLETE = 2'd3
   } state_t;

   state_t             state_reg;
   logic [PTR_W-1:0]   ptr_reg;
   logic [SEL_W-1:0]   src_reg;
   logic [SEL_W-1:0]   dst_reg;

   // Arbitration result for the current IDLE cycle.
   logic [PTR_W-1:0]   pick;
   logic [PTR_W-1:0]   pick_next;
   logic [PTR_W-1:0]   idx;
   logic [N_REQ-1:0]   pick_hot;
   logic [SEL_W-1:0]   sel_src;
   logic [SEL_W-1:0]   sel_dst;

   // One-hot decodes; an out-of-range index simply decodes to all zeros,
   // which suppresses the corresponding strobe.
   logic [N_REG-1:0]   sel_src_hot;
   logic [N_REG-1:0]   src_hot;
   logic [N_REG-1:0]   dst_hot;

   // Search downward in offset from the pointer so that the smallest offset
   // that has a request is the last (and winning) assignment.
   always_comb begin
      pick = '0;
      idx  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = PTR_W'((int'(ptr_reg) + k) % N_REQ);
         if (REQ[idx]) begin
            pick = idx;
         end
      end
   end

   always_comb begin
      pick_next = (pick == PTR_W'(N_REQ - 1)) ? '0 : pick + PTR_W'(1);
      pick_hot  = '0;
      sel_src   = '0;
      sel_dst   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick == PTR_W'(i)) begin
            pick_hot[i] = 1'b1;
            sel_src     = SRC[i*SEL_W +: SEL_W];
            sel_dst     = DST[i*SEL_W +: SEL_W];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < N_REG; gi++) begin : g_decode
         assign sel_src_hot[gi] = (sel_src == SEL_W'(gi));
         assign src_hot[gi]     = (src_reg == SEL_W'(gi));
         assign dst_hot[gi]     = (dst_reg == SEL_W'(gi));
      end
   endgenerate

   // sel_dst is latched for later decoding; only the source strobe is needed
   // on the arbitration edge itself.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         src_reg   <= '0;
         dst_reg   <= '0;
         GNT       <= '0;
         DONE      <= '0;
         ERR       <= 1'b0;
         LDBUS     <= '0;
         WR        <= '0;
         BUSY      <= 1'b0;
      end else begin
         DONE <= '0;
         ERR  <= 1'b0;
         unique case (state_reg)
            IDLE: begin
               if (|REQ) begin
                  state_reg <= DRIVE;
                  ptr_reg   <= pick_next;
                  src_reg   <= sel_src;
                  dst_reg   <= sel_dst;
                  GNT       <= pick_hot;
                  LDBUS     <= sel_src_hot;
                  BUSY      <= 1'b1;
               end
            end
            DRIVE: begin
               // LDBUS stays asserted so the bus is stable a full cycle
               // before the capturing edge.
               state_reg <= WRITE;
               WR        <= dst_hot;
            end
            WRITE: begin
               state_reg <= COMPLETE;
               LDBUS     <= '0;
               WR        <= '0;
               DONE      <= GNT;
               ERR       <= ~(|src_hot) | ~(|dst_hot);
            end
            COMPLETE: begin
               state_reg <= IDLE;
               GNT       <= '0;
               BUSY      <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_transfer_arbiter
//
// Self-checking bench for bus_transfer_arbiter (N_REQ=4, N_REG=6, SEL_W=3).
// A transaction-level reference model (round-robin pointer plus a per-cycle
// expected output table) predicts the outputs of each transfer. A small
// behavioural register file driven by LDBUS/WR shows the data movement.
// -----------------------------------------------------------------------------
module tb_bus_transfer_arbiter;

   localparam int NREQ = 4;
   localparam int NREG = 6;
   localparam int SW   = 3;

   logic                 clk = 1'b0;
   logic                 RST = 1'b0;
   logic [NREQ-1:0]      REQ = '0;
   logic [NREQ*SW-1:0]   SRC = '0;
   logic [NREQ*SW-1:0]   DST = '0;
   logic [NREQ-1:0]      GNT;
   logic [NREQ-1:0]      DONE;
   logic                 ERR;
   logic [NREG-1:0]      LDBUS;
   logic [NREG-1:0]      WR;
   logic                 BUSY;

   typedef struct packed {
      logic [NREQ-1:0] gnt;
      logic [NREQ-1:0] done;
      logic            err;
      logic [NREG-1:0] ld;
      logic [NREG-1:0] wr;
      logic            busy;
   } outs_t;

   outs_t       cur;
   outs_t       obs [4];
   int          total = 0;
   int          bad   = 0;
   int          m_ptr = 0;
   logic [15:0] regs [NREG];
   logic [15:0] bus;

   bus_transfer_arbiter #(.N_REQ(NREQ), .N_REG(NREG), .SEL_W(SW)) dut (
      .clk   (clk),
      .RST   (RST),
      .REQ   (REQ),
      .SRC   (SRC),
      .DST   (DST),
      .GNT   (GNT),
      .DONE  (DONE),
      .ERR   (ERR),
      .LDBUS (LDBUS),
      .WR    (WR),
      .BUSY  (BUSY)
   );

   always #5 clk = ~clk;

   assign cur = {GNT, DONE, ERR, LDBUS, WR, BUSY};

   // Behavioural register file on the shared bus.
   always_comb begin
      bus = '0;
      for (int i = 0; i < NREG; i++) begin
         if (LDBUS[i]) bus = bus | regs[i];
      end
   end

   always @(posedge clk) begin
      if (RST) begin
         for (int i = 0; i < NREG; i++) regs[i] <= 16'(16'h1111 * i);
         regs[2] <= 16'hA5A5;
      end else begin
         for (int j = 0; j < NREG; j++) begin
            if (WR[j]) regs[j] <= bus;
         end
      end
   end

   // Reference model: first set request at or after the pointer, wrapping.
   function automatic int model_grant(input logic [NREQ-1:0] req);
      int w = -1;
      for (int k = 0; k < NREQ && w < 0; k++) begin
         if (req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      end
      if (w >= 0) m_ptr = (w + 1) % NREQ;
      return w;
   endfunction

   function automatic int field(input logic [NREQ*SW-1:0] vec, input int i);
      logic [NREQ*SW-1:0] t;
      t = vec >> (i * SW);
      return int'(t[SW-1:0]);
   endfunction

   // Expected outputs c cycles after the arbitration edge (c=0 is DRIVE).
   function automatic outs_t expect_cycle(input int c, input int w, input int s, input int d);
      outs_t e;
      e = '0;
      if (c < 3) begin
         e.gnt[w] = 1'b1;
         e.busy   = 1'b1;
      end
      if (c < 2 && s < NREG) e.ld[s] = 1'b1;
      if (c == 1 && d < NREG) e.wr[d] = 1'b1;
      if (c == 2) begin
         e.done[w] = 1'b1;
         e.err     = (s >= NREG) || (d >= NREG);
      end
      return e;
   endfunction

   // Drives one request set from a negedge and records the four cycles after
   // the arbitration edge. mode 0: drop REQ after DONE; 1: hold REQ;
   // 2: drop REQ and scramble SRC/DST during DRIVE.
   task automatic run_txn(input logic [NREQ-1:0] req, input logic [NREQ*SW-1:0] src,
                          input logic [NREQ*SW-1:0] dst, input int mode);
      REQ = req;
      SRC = src;
      DST = dst;
      @(posedge clk);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         obs[c] = cur;
         if (mode == 2 && c == 0) begin
            REQ = '0;
            SRC = ~src;
            DST = ~dst;
         end
         if (mode == 0 && c == 2) REQ = '0;
      end
   endtask

   task automatic do_reset;
      RST = 1'b1;
      REQ = '0;
      repeat (2) @(negedge clk);
      RST   = 1'b0;
      m_ptr = 0;
   endtask

   task automatic test_reset;
      #3;
      RST = 1'b1;
      #1;
      total++;
      if (cur !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0", cur);
      end
      @(negedge clk);
      @(negedge clk);
      RST   = 1'b0;
      m_ptr = 0;
      total++;
      if (cur !== '0) begin
         bad++;
         $display("FAIL reset_release got=%h want=0", cur);
      end
   endtask

   task automatic test_single;
      outs_t e;
      int    w;
      w = model_grant(4'b0001);
      run_txn(4'b0001, 12'h002, 12'h005, 0);
      for (int c = 0; c < 4; c++) begin
         e = expect_cycle(c, w, 2, 5);
         total++;
         if (obs[c] !== e) begin
            bad++;
            $display("FAIL single c%0d got=%h want=%h", c, obs[c], e);
         end
      end
      total++;
      if (regs[5] !== 16'hA5A5) begin
         bad++;
         $display("FAIL single_r5 got=%h want=a5a5", regs[5]);
      end
   endtask

   task automatic test_round_robin;
      int                 order [5] = '{0, 1, 2, 3, 0};
      logic [NREQ*SW-1:0] src, dst;
      outs_t              e;
      int                 w;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         src = NREQ*SW'($urandom);
         dst = NREQ*SW'($urandom);
         w   = model_grant(4'b1111);
         run_txn(4'b1111, src, dst, 1);
         total++;
         if (obs[0].gnt !== (4'b0001 << order[k])) begin
            bad++;
            $display("FAIL rr_order k%0d got=%b want=%0d", k, obs[0].gnt, order[k]);
         end
         for (int c = 0; c < 4; c++) begin
            e = expect_cycle(c, w, field(src, w), field(dst, w));
            total++;
            if (obs[c] !== e) begin
               bad++;
               $display("FAIL rr k%0d c%0d got=%h want=%h", k, c, obs[c], e);
            end
         end
      end
   endtask

   task automatic test_pointer_wrap;
      int want [2] = '{0, 2};
      int w;
      w = model_grant(4'b0100);
      run_txn(4'b0100, 12'h123, 12'h321, 0);
      total++;
      if (obs[0].gnt !== 4'b0100) begin
         bad++;
         $display("FAIL wrap_setup got=%b want=0100", obs[0].gnt);
      end
      for (int k = 0; k < 2; k++) begin
         w = model_grant(4'b0101);
         run_txn(4'b0101, 12'h031, 12'h024, (k == 0) ? 1 : 0);
         total++;
         if (obs[0].gnt !== (4'b0001 << want[k]) || obs[2].done !== (4'b0001 << w)) begin
            bad++;
            $display("FAIL wrap k%0d got gnt=%b done=%b want=%0d", k, obs[0].gnt, obs[2].done, want[k]);
         end
      end
   endtask

   task automatic test_mid_change;
      logic [15:0] pre;
      outs_t       e;
      int          w;
      pre = regs[3];
      w   = model_grant(4'b0001);
      run_txn(4'b0001, 12'h003, 12'h004, 2);
      for (int c = 0; c < 4; c++) begin
         e = expect_cycle(c, w, 3, 4);
         total++;
         if (obs[c] !== e) begin
            bad++;
            $display("FAIL midchange c%0d got=%h want=%h", c, obs[c], e);
         end
      end
      total++;
      if (regs[4] !== pre) begin
         bad++;
         $display("FAIL midchange_data got=%h want=%h", regs[4], pre);
      end
   endtask

   task automatic test_out_of_range;
      outs_t e;
      int    w;
      w = model_grant(4'b0001);
      run_txn(4'b0001, 12'h007, 12'h001, 0);
      total++;
      if (obs[0].ld !== '0 || obs[1].ld !== '0 || obs[1].wr !== 6'b000010) begin
         bad++;
         $display("FAIL oor_strobes got ld=%b,%b wr=%b want ld=0 wr=000010",
                  obs[0].ld, obs[1].ld, obs[1].wr);
      end
      total++;
      if (obs[2].err !== 1'b1 || obs[2].done !== 4'b0001) begin
         bad++;
         $display("FAIL oor_err got err=%b done=%b want err=1 done=0001", obs[2].err, obs[2].done);
      end
      for (int c = 0; c < 4; c++) begin
         e = expect_cycle(c, w, 7, 1);
         total++;
         if (obs[c] !== e) begin
            bad++;
            $display("FAIL oor c%0d got=%h want=%h", c, obs[c], e);
         end
      end
   endtask

   task automatic test_random;
      logic [NREQ-1:0]    req;
      logic [NREQ*SW-1:0] src, dst;
      outs_t              e;
      int                 w;
      for (int k = 0; k < 20; k++) begin
         req = NREQ'($urandom_range(1, 15));
         src = NREQ*SW'($urandom);
         dst = NREQ*SW'($urandom);
         w   = model_grant(req);
         run_txn(req, src, dst, int'($urandom_range(0, 1)));
         for (int c = 0; c < 4; c++) begin
            e = expect_cycle(c, w, field(src, w), field(dst, w));
            total++;
            if (obs[c] !== e) begin
               bad++;
               $display("FAIL random k%0d c%0d req=%b got=%h want=%h", k, c, req, obs[c], e);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      int want [2] = '{0, 1};
      int w;
      REQ = 4'b0001;
      SRC = 12'h002;
      DST = 12'h005;
      @(posedge clk);
      @(posedge clk);
      #2;
      total++;
      if (WR !== 6'b100000) begin
         bad++;
         $display("FAIL rstmid_write got=%b want=100000", WR);
      end
      RST = 1'b1;
      #1;
      total++;
      if (cur !== '0) begin
         bad++;
         $display("FAIL rstmid_async got=%h want=0", cur);
      end
      REQ = '0;
      @(negedge clk);
      @(negedge clk);
      RST   = 1'b0;
      m_ptr = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (cur !== '0) begin
            bad++;
            $display("FAIL rstmid_quiet c%0d got=%h want=0", c, cur);
         end
      end
      for (int k = 0; k < 2; k++) begin
         w = model_grant((k == 0) ? 4'b0011 : 4'b0010);
         run_txn((k == 0) ? 4'b0011 : 4'b0010, 12'h011, 12'h022, 0);
         total++;
         if (obs[0].gnt !== (4'b0001 << want[k]) || obs[2].done !== (4'b0001 << w)) begin
            bad++;
            $display("FAIL rstmid_grant k%0d got gnt=%b done=%b want=%0d",
                     k, obs[0].gnt, obs[2].done, want[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_pointer_wrap();
      test_mid_change();
      test_out_of_range();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
